udma_uart_rx_buffer: RTL



---
 rtl/udma_uart_rx_buffer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/udma_uart_rx_buffer.sv
// UART RX receive buffer: character FIFO with parity flags, DMA or register drain,
// level/timeout interrupt and RTS flow control with watermark hysteresis.
module udma_uart_rx_buffer #(
  parameter int unsigned DATA_WIDTH = 9,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned TIMEOUT_W  = 16,
  localparam int unsigned CW        = $clog2(DEPTH) + 1
) (
  input  logic                  sys_clk_i,
  input  logic                  rstn_i,
  input  logic                  clr_i,
  input  logic [1:0]            cfg_mode_i,
  input  logic                  cfg_rts_en_i,
  input  logic [CW-1:0]         cfg_hi_wm_i,
  input  logic [CW-1:0]         cfg_lo_wm_i,
  input  logic [CW-1:0]         cfg_irq_thr_i,
  input  logic [TIMEOUT_W-1:0]  cfg_timeout_i,
  input  logic [DATA_WIDTH-1:0] char_data_i,
  input  logic                  char_valid_i,
  input  logic                  char_err_parity_i,
  output logic [31:0]           data_rx_o,
  output logic                  data_rx_valid_o,
  input  logic                  data_rx_ready_i,
  input  logic                  poll_rd_i,
  output logic [31:0]           poll_data_o,
  output logic [CW-1:0]         level_o,
  output logic                  rts_no,
  output logic                  rx_irq_o,
  output logic                  timeout_event_o,
  output logic                  overflow_event_o,
  output logic                  parity_event_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {StReady, StStop} rts_state_e;

  logic [DATA_WIDTH:0]  mem_q [DEPTH];
  logic [AW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [1:0]           mode_q;
  logic [TIMEOUT_W-1:0] to_cnt_q, to_cnt_d;
  logic                 to_pend_q, to_pend_d;
  logic                 to_evt_q, to_evt_d;
  logic                 ovf_q, ovf_d;
  logic                 par_q, par_d;
  logic                 irq_q, irq_d;
  rts_state_e           rts_q, rts_d;

  logic                 empty, full, dma_mode, pop, push;
  logic [DATA_WIDTH:0]  head;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    dma_mode = (mode_q == 2'b00);
    pop      = !clr_i && !empty && (dma_mode ? data_rx_ready_i : poll_rd_i);
    // A full FIFO still accepts a character when a pop frees a slot this cycle.
    push     = !clr_i && char_valid_i && (!full || pop);
    ovf_d    = !clr_i && char_valid_i && full && !pop;
    par_d    = push && char_err_parity_i;
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clr_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Idle timer only runs while data sits untouched; it parks at the limit after firing.
  always_comb begin
    to_cnt_d  = to_cnt_q;
    to_pend_d = to_pend_q;
    to_evt_d  = 1'b0;
    if (clr_i) begin
      to_cnt_d  = '0;
      to_pend_d = 1'b0;
    end else begin
      if (pop) to_pend_d = 1'b0;
      if (push || pop || empty || (cfg_timeout_i == '0)) begin
        to_cnt_d = '0;
      end else if (to_cnt_q < cfg_timeout_i) begin
        to_cnt_d = to_cnt_q + TIMEOUT_W'(1);
        if (to_cnt_d == cfg_timeout_i) begin
          to_evt_d  = 1'b1;
          to_pend_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rts_d = rts_q;
    irq_d = 1'b0;
    if (clr_i || !cfg_rts_en_i) begin
      rts_d = StReady;
    end else begin
      unique case (rts_q)
        StReady: if (count_q >= cfg_hi_wm_i) rts_d = StStop;
        StStop:  if (count_q <= cfg_lo_wm_i) rts_d = StReady;
      endcase
    end
    if (!clr_i && (mode_q == 2'b10)) begin
      irq_d = ((cfg_irq_thr_i != '0) && (count_q >= cfg_irq_thr_i)) || to_pend_q;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (push) mem_q[wptr_q] <= {char_err_parity_i, char_data_i};
  end

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      mode_q    <= 2'b00;
      to_cnt_q  <= '0;
      to_pend_q <= 1'b0;
      to_evt_q  <= 1'b0;
      ovf_q     <= 1'b0;
      par_q     <= 1'b0;
      irq_q     <= 1'b0;
      rts_q     <= StReady;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      mode_q    <= cfg_mode_i;
      to_cnt_q  <= to_cnt_d;
      to_pend_q <= to_pend_d;
      to_evt_q  <= to_evt_d;
      ovf_q     <= ovf_d;
      par_q     <= par_d;
      irq_q     <= irq_d;
      rts_q     <= rts_d;
    end
  end

  // Head is masked when empty so stale storage never reaches the outputs.
  always_comb begin
    head        = mem_q[rptr_q];
    data_rx_o   = '0;
    poll_data_o = '0;
    if (!empty) begin
      data_rx_o                    = 32'(head[DATA_WIDTH-1:0]);
      poll_data_o[DATA_WIDTH-1:0]  = head[DATA_WIDTH-1:0];
      poll_data_o[16]              = 1'b1;
      poll_data_o[17]              = head[DATA_WIDTH];
    end
  end

  assign data_rx_valid_o  = dma_mode && !empty;
  assign level_o          = count_q;
  assign rts_no           = (rts_q == StStop);
  assign rx_irq_o         = irq_q;
  assign timeout_event_o  = to_evt_q;
  assign overflow_event_o = ovf_q;
  assign parity_event_o   = par_q;

endmodule
